// File: rtl/soc_ctrl_sequencer_pkg.sv
// Shared opcodes, FSM states and helpers for the SOC control sequencer.
// Optional halt-drain timeout is enabled with SOC_CTRL_HALT_TIMEOUT_EN.
package soc_ctrl_sequencer_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_RESUME = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_REG_RD = 3'd4;
    localparam logic [2:0] OP_REG_WR = 3'd5;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    typedef enum logic [3:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_STEP_RUN,
        S_STEP_DRAIN,
        S_REG_RD,
        S_REG_RD_CAP,
        S_REG_WR,
        S_RSP
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_REG_WR;
    endfunction

endpackage

// File: rtl/soc_ctrl_halt_timer.sv
// Wait-cycle counter with expiry flag for halt/step draining.
// Instantiated only when SOC_CTRL_HALT_TIMEOUT_EN is defined.
module soc_ctrl_halt_timer #(
    parameter int LIMIT = 1024,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          expired
);

    assign expired = (count == CW'(LIMIT));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/soc_ctrl_sequencer.sv
// Halt/resume/step and register-file access sequencer for the rv32i core.
// Define SOC_CTRL_HALT_TIMEOUT_EN to abort stuck HALT/STEP drains.
module soc_ctrl_sequencer
    import soc_ctrl_sequencer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter bit BOOT_HALTED  = 1'b0,
    parameter int HALT_TIMEOUT = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    input  logic                  core_idle,
    input  logic                  retire,
    output logic                  pc_stall,
    output logic                  cm_cpu_stop,
    output logic                  cm_regfile_we,
    output logic [REG_ADDR_W-1:0] cm_read_write_regfile_addr,
    output logic [DATA_W-1:0]     cm_write_regfile_dat,
    input  logic [DATA_W-1:0]     cm_read_regfile_dat,
    output logic                  halted
);

    localparam int TW = $clog2(HALT_TIMEOUT + 1);

    state_e                state, state_n;
    logic                  ret_halt, ret_halt_n;
    logic                  pc_stall_n, stop_n, halted_n;
    logic                  rsp_valid_n, rsp_err_n, we_n;
    logic [DATA_W-1:0]     rsp_data_n, wdata_n;
    logic [REG_ADDR_W-1:0] addr_n;
    logic                  accept, tmo;
    logic [TW-1:0]         tmr_cnt;

    assign cmd_ready = (state == S_RUN) || (state == S_HALTED);
    assign accept    = cmd_valid && cmd_ready;

`ifdef SOC_CTRL_HALT_TIMEOUT_EN
    logic wait_st, tmr_clr;

    assign wait_st = state inside {S_DRAIN, S_STEP_RUN, S_STEP_DRAIN};
    assign tmr_clr = (state_n != state) &&
                     (state_n inside {S_DRAIN, S_STEP_RUN, S_STEP_DRAIN});

    soc_ctrl_halt_timer #(
        .LIMIT(HALT_TIMEOUT),
        .CW   (TW)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (tmr_clr),
        .en     (wait_st),
        .count  (tmr_cnt),
        .expired(tmo)
    );
`else
    assign tmo     = 1'b0;
    assign tmr_cnt = '0;
`endif

    always_comb begin
        state_n     = state;
        ret_halt_n  = ret_halt;
        pc_stall_n  = pc_stall;
        stop_n      = cm_cpu_stop;
        halted_n    = halted;
        rsp_valid_n = rsp_valid;
        rsp_err_n   = rsp_err;
        rsp_data_n  = rsp_data;
        we_n        = 1'b0;
        addr_n      = cm_read_write_regfile_addr;
        wdata_n     = cm_write_regfile_dat;
        unique case (state)
            S_RUN: begin
                if (accept) begin
                    ret_halt_n  = 1'b0;
                    state_n     = S_RSP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_err_n   = RSP_ERR;
                    unique case (1'b1)
                        !op_legal(cmd_op): ;
                        cmd_op == OP_HALT: begin
                            state_n     = S_DRAIN;
                            rsp_valid_n = 1'b0;
                            rsp_err_n   = RSP_OK;
                            pc_stall_n  = 1'b1;
                        end
                        cmd_op == OP_RESUME,
                        cmd_op == OP_NOP: rsp_err_n = RSP_OK;
                        default: ;
                    endcase
                end
            end
            S_HALTED: begin
                if (accept) begin
                    ret_halt_n  = 1'b1;
                    state_n     = S_RSP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_err_n   = RSP_OK;
                    unique case (1'b1)
                        !op_legal(cmd_op): rsp_err_n = RSP_ERR;
                        cmd_op == OP_RESUME: begin
                            ret_halt_n = 1'b0;
                            pc_stall_n = 1'b0;
                            stop_n     = 1'b0;
                            halted_n   = 1'b0;
                        end
                        cmd_op == OP_STEP: begin
                            state_n     = S_STEP_RUN;
                            rsp_valid_n = 1'b0;
                            pc_stall_n  = 1'b0;
                            stop_n      = 1'b0;
                            halted_n    = 1'b0;
                        end
                        cmd_op == OP_REG_RD: begin
                            state_n     = S_REG_RD;
                            rsp_valid_n = 1'b0;
                            addr_n      = cmd_addr;
                        end
                        cmd_op == OP_REG_WR: begin
                            state_n     = S_REG_WR;
                            rsp_valid_n = 1'b0;
                            we_n        = 1'b1;
                            addr_n      = cmd_addr;
                            wdata_n     = cmd_data;
                        end
                        default: ;
                    endcase
                end
            end
            // The release cycle itself may carry the retire of the stepped insn.
            S_STEP_RUN: begin
                pc_stall_n = 1'b1;
                if (retire) begin
                    state_n = S_STEP_DRAIN;
                end
            end
            S_REG_RD:     state_n = S_REG_RD_CAP;
            S_REG_RD_CAP: begin
                state_n     = S_RSP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = RSP_OK;
                rsp_data_n  = cm_read_regfile_dat;
            end
            S_REG_WR: begin
                state_n     = S_RSP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = RSP_OK;
                rsp_data_n  = '0;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_n     = ret_halt ? S_HALTED : S_RUN;
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = RSP_OK;
                    rsp_data_n  = '0;
                end
            end
            default: ;
        endcase
        if ((state == S_DRAIN) || (state == S_STEP_DRAIN)) begin
            if (core_idle) begin
                state_n     = S_RSP;
                ret_halt_n  = 1'b1;
                stop_n      = 1'b1;
                halted_n    = 1'b1;
                rsp_valid_n = 1'b1;
                rsp_err_n   = RSP_OK;
                rsp_data_n  = '0;
            end
        end
        // Drain never finished: give up and assume the core keeps running.
        if (tmo && (state_n == state)) begin
            state_n     = S_RSP;
            ret_halt_n  = 1'b0;
            pc_stall_n  = 1'b0;
            stop_n      = 1'b0;
            halted_n    = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_err_n   = RSP_ERR;
            rsp_data_n  = DATA_W'(tmr_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state                      <= BOOT_HALTED ? S_HALTED : S_RUN;
            ret_halt                   <= BOOT_HALTED;
            pc_stall                   <= BOOT_HALTED;
            cm_cpu_stop                <= BOOT_HALTED;
            halted                     <= BOOT_HALTED;
            rsp_valid                  <= 1'b0;
            rsp_err                    <= 1'b0;
            rsp_data                   <= '0;
            cm_regfile_we              <= 1'b0;
            cm_read_write_regfile_addr <= '0;
            cm_write_regfile_dat       <= '0;
        end else begin
            state                      <= state_n;
            ret_halt                   <= ret_halt_n;
            pc_stall                   <= pc_stall_n;
            cm_cpu_stop                <= stop_n;
            halted                     <= halted_n;
            rsp_valid                  <= rsp_valid_n;
            rsp_err                    <= rsp_err_n;
            rsp_data                   <= rsp_data_n;
            cm_regfile_we              <= we_n;
            cm_read_write_regfile_addr <= addr_n;
            cm_write_regfile_dat       <= wdata_n;
        end
    end

    we_needs_stop: assert property (
        @(posedge CLK) disable iff (RST) cm_regfile_we |-> cm_cpu_stop
    );

endmodule

// File: tb/tb_soc_ctrl_sequencer.sv
// Directed self-checking bench for soc_ctrl_sequencer.
// Covers the SOC_CTRL_HALT_TIMEOUT_EN build when that macro is defined.
module tb_soc_ctrl_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          core_idle = 1'b1;
    logic          retire = 1'b0;
    logic          pc_stall;
    logic          cm_cpu_stop;
    logic          cm_regfile_we;
    logic [AW-1:0] cm_addr;
    logic [DW-1:0] cm_wdat;
    logic [DW-1:0] cm_rdat;
    logic          halted;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;

    logic [DW-1:0] rf [32];

    always #5 CLK = ~CLK;

    soc_ctrl_sequencer #(
        .DATA_W      (DW),
        .REG_ADDR_W  (AW),
        .BOOT_HALTED (1'b0),
        .HALT_TIMEOUT(16)
    ) dut (
        .CLK                       (CLK),
        .RST                       (RST),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_op                    (cmd_op),
        .cmd_addr                  (cmd_addr),
        .cmd_data                  (cmd_data),
        .rsp_valid                 (rsp_valid),
        .rsp_ready                 (rsp_ready),
        .rsp_data                  (rsp_data),
        .rsp_err                   (rsp_err),
        .core_idle                 (core_idle),
        .retire                    (retire),
        .pc_stall                  (pc_stall),
        .cm_cpu_stop               (cm_cpu_stop),
        .cm_regfile_we             (cm_regfile_we),
        .cm_read_write_regfile_addr(cm_addr),
        .cm_write_regfile_dat      (cm_wdat),
        .cm_read_regfile_dat       (cm_rdat),
        .halted                    (halted)
    );

    // Register file with one-cycle read latency; x0 is hardwired to zero.
    always @(posedge CLK) begin
        if (cm_regfile_we && cm_addr != 0) rf[cm_addr] <= cm_wdat;
        cm_rdat <= rf[cm_addr];
        if (cm_regfile_we) we_cnt <= we_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL send_ready_timeout op=%0d cmd_ready=%b want 1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int max, output bit got, output int lat,
                           output logic [DW-1:0] d, output logic e);
        got = 1'b0;
        lat = 0;
        d   = '0;
        e   = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                lat = i;
                d   = rsp_data;
                e   = rsp_err;
                break;
            end
            tick();
        end
        if (got) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, cm_regfile_we, pc_stall, cm_cpu_stop, halted}
            !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=1000000",
                     {cmd_ready, rsp_valid, rsp_err, cm_regfile_we, pc_stall, cm_cpu_stop, halted});
        end
        checks++;
        if ({rsp_data, cm_addr, cm_wdat} !== '0) begin
            failures++;
            $display("FAIL reset_data rsp_data=%h addr=%h wdat=%h want 0", rsp_data, cm_addr, cm_wdat);
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, pc_stall, cm_cpu_stop, halted} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_release got=%b want=10000",
                     {cmd_ready, rsp_valid, pc_stall, cm_cpu_stop, halted});
        end
    endtask

    task automatic test_run_cmds();
        logic [2:0] ops  [7] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd7, 3'd5, 3'd6};
        logic       errs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int b = we_cnt;
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        for (int i = 0; i < 7; i++) begin
            send(ops[i], 5'd1, 32'hA5A5_0000);
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL run_gap op=%0d cmd_ready=%b want 0", ops[i], cmd_ready);
            end
            get_rsp(5, got, lat, d, e);
            checks++;
            if (!got || lat != 0 || e !== errs[i] || d !== '0) begin
                failures++;
                $display("FAIL run_op%0d got=%0b lat=%0d err=%b data=%h want lat=0 err=%b data=0",
                         ops[i], got, lat, e, d, errs[i]);
            end
        end
        checks++;
        if (we_cnt != b || {pc_stall, cm_cpu_stop, halted, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL run_side_effect we=%0d stall/stop/halt/ready=%b want we=0 0001",
                     we_cnt - b, {pc_stall, cm_cpu_stop, halted, cmd_ready});
        end
    endtask

    task automatic test_halt();
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        core_idle = 1'b0;
        send(3'd1, '0, '0);
        checks++;
        if ({pc_stall, cm_cpu_stop, halted, rsp_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL halt_stall got=%b want=1000", {pc_stall, cm_cpu_stop, halted, rsp_valid});
        end
        repeat (3) tick();
        checks++;
        if ({pc_stall, cm_cpu_stop, halted, rsp_valid, cmd_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL halt_drain got=%b want=10000",
                     {pc_stall, cm_cpu_stop, halted, rsp_valid, cmd_ready});
        end
        core_idle = 1'b1;
        tick();
        checks++;
        if ({halted, cm_cpu_stop, pc_stall, rsp_valid, rsp_err} !== 5'b11110) begin
            failures++;
            $display("FAIL halt_done got=%b want=11110",
                     {halted, cm_cpu_stop, pc_stall, rsp_valid, rsp_err});
        end
        get_rsp(2, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || {cmd_ready, halted, pc_stall} !== 3'b111) begin
            failures++;
            $display("FAIL halt_rsp got=%0b err=%b ready/halt/stall=%b want 1 0 111",
                     got, e, {cmd_ready, halted, pc_stall});
        end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tick();
        checks++;
        if ({halted, cmd_ready, rsp_valid, cm_cpu_stop} !== 4'b1101) begin
            failures++;
            $display("FAIL halted_retire got=%b want=1101", {halted, cmd_ready, rsp_valid, cm_cpu_stop});
        end
        send(3'd1, '0, '0);
        get_rsp(2, got, lat, d, e);
        checks++;
        if (!got || lat != 0 || e !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_again got=%0b lat=%0d err=%b halted=%b want 1 0 0 1", got, lat, e, halted);
        end
    endtask

    task automatic test_regs();
        int b = we_cnt;
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        send(3'd5, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (cm_regfile_we !== 1'b1 || cm_addr !== 5'd5 || cm_wdat !== 32'hDEAD_BEEF || !cm_cpu_stop) begin
            failures++;
            $display("FAIL wr_strobe we=%b addr=%0d wdat=%h stop=%b want 1 5 deadbeef 1",
                     cm_regfile_we, cm_addr, cm_wdat, cm_cpu_stop);
        end
        tick();
        checks++;
        if (cm_regfile_we !== 1'b0) begin
            failures++;
            $display("FAIL wr_pulse we=%b want 0", cm_regfile_we);
        end
        get_rsp(3, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || we_cnt - b != 1 || rf[5] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_rsp got=%0b err=%b pulses=%0d x5=%h want 1 0 1 deadbeef",
                     got, e, we_cnt - b, rf[5]);
        end
        send(3'd4, 5'd5, '0);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_early1 rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cm_addr !== 5'd5) begin
            failures++;
            $display("FAIL rd_early2 rsp_valid=%b addr=%0d want 0 5", rsp_valid, cm_addr);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_x5 valid=%b data=%h err=%b want 1 deadbeef 0", rsp_valid, rsp_data, rsp_err);
        end
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rd_hold valid=%b data=%h ready=%b want 1 deadbeef 0",
                     rsp_valid, rsp_data, cmd_ready);
        end
        get_rsp(1, got, lat, d, e);
        checks++;
        if (!got || rsp_valid !== 1'b0 || rsp_data !== '0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_release got=%0b valid=%b data=%h ready=%b want 1 0 0 1",
                     got, rsp_valid, rsp_data, cmd_ready);
        end
        b = we_cnt;
        send(3'd5, 5'd0, 32'h1234_5678);
        get_rsp(3, got, lat, d, e);
        send(3'd4, 5'd0, '0);
        get_rsp(4, got, lat, d, e);
        checks++;
        if (!got || lat != 2 || d !== '0 || e !== 1'b0 || we_cnt - b != 1) begin
            failures++;
            $display("FAIL rd_x0 got=%0b lat=%0d data=%h err=%b pulses=%0d want 1 2 0 0 1",
                     got, lat, d, e, we_cnt - b);
        end
        send(3'd4, 5'd7, '0);
        get_rsp(4, got, lat, d, e);
        checks++;
        if (!got || lat != 2 || d !== 32'h0707_0707 || e !== 1'b0) begin
            failures++;
            $display("FAIL rd_x7 got=%0b lat=%0d data=%h err=%b want 1 2 07070707 0", got, lat, d, e);
        end
    endtask

    task automatic test_step();
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        send(3'd3, '0, '0);
        checks++;
        if ({pc_stall, cm_cpu_stop, halted, rsp_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL step_release got=%b want=0000", {pc_stall, cm_cpu_stop, halted, rsp_valid});
        end
        core_idle = 1'b0;
        tick();
        checks++;
        if ({pc_stall, cm_cpu_stop} !== 2'b10) begin
            failures++;
            $display("FAIL step_one_cycle stall/stop=%b want=10", {pc_stall, cm_cpu_stop});
        end
        repeat (2) tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;
        repeat (2) tick();
        checks++;
        if (rsp_valid !== 1'b0 || cm_cpu_stop !== 1'b0) begin
            failures++;
            $display("FAIL step_wait_idle valid=%b stop=%b want 0 0", rsp_valid, cm_cpu_stop);
        end
        core_idle = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, halted, cm_cpu_stop, pc_stall} !== 5'b10111) begin
            failures++;
            $display("FAIL step_done got=%b want=10111",
                     {rsp_valid, rsp_err, halted, cm_cpu_stop, pc_stall});
        end
        get_rsp(2, got, lat, d, e);
        checks++;
        if (!got || cmd_ready !== 1'b1 || halted !== 1'b1) begin
            failures++;
            $display("FAIL step_rsp got=%0b ready=%b halted=%b want 1 1 1", got, cmd_ready, halted);
        end
        send(3'd3, '0, '0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, halted, cm_cpu_stop} !== 4'b1011) begin
            failures++;
            $display("FAIL step_fast got=%b want=1011", {rsp_valid, rsp_err, halted, cm_cpu_stop});
        end
        get_rsp(2, got, lat, d, e);
    endtask

    task automatic test_resume();
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        send(3'd2, '0, '0);
        checks++;
        if ({pc_stall, cm_cpu_stop, halted, rsp_valid, rsp_err} !== 5'b00010) begin
            failures++;
            $display("FAIL resume got=%b want=00010", {pc_stall, cm_cpu_stop, halted, rsp_valid, rsp_err});
        end
        get_rsp(2, got, lat, d, e);
        send(3'd5, 5'd2, 32'h1);
        get_rsp(2, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL resume_run got=%0b err=%b halted=%b want 1 1 0", got, e, halted);
        end
    endtask

    task automatic test_timeout();
        bit got;
        int lat;
        logic [DW-1:0] d;
        logic e;
        core_idle = 1'b0;
        send(3'd1, '0, '0);
`ifdef SOC_CTRL_HALT_TIMEOUT_EN
        get_rsp(40, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b1 || d !== 32'd16) begin
            failures++;
            $display("FAIL timeout_rsp got=%0b err=%b data=%0d want 1 1 16", got, e, d);
        end
        checks++;
        if ({pc_stall, cm_cpu_stop, halted, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_state got=%b want=0001", {pc_stall, cm_cpu_stop, halted, cmd_ready});
        end
        core_idle = 1'b1;
        send(3'd4, 5'd1, '0);
        get_rsp(4, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b1) begin
            failures++;
            $display("FAIL timeout_run got=%0b err=%b want 1 1", got, e);
        end
`else
        get_rsp(40, got, lat, d, e);
        checks++;
        if (got || pc_stall !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_wait got=%0b stall=%b ready=%b want 0 1 0", got, pc_stall, cmd_ready);
        end
        core_idle = 1'b1;
        get_rsp(3, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL drain_late got=%0b err=%b halted=%b want 1 0 1", got, e, halted);
        end
        send(3'd2, '0, '0);
        get_rsp(2, got, lat, d, e);
`endif
    endtask

    task automatic test_reset_mid();
        core_idle = 1'b0;
        send(3'd1, '0, '0);
        tick();
        RST       = 1'b1;
        core_idle = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, cm_regfile_we, pc_stall, cm_cpu_stop, halted}
            !== 7'b1000000 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b data=%h want=1000000 0",
                     {cmd_ready, rsp_valid, rsp_err, cm_regfile_we, pc_stall, cm_cpu_stop, halted},
                     rsp_data);
        end
        RST = 1'b0;
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || pc_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stale valid=%b ready=%b stall=%b want 0 1 0",
                     rsp_valid, cmd_ready, pc_stall);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : DW'(i) * 32'h0101_0101;
        test_reset();
        test_run_cmds();
        test_halt();
        test_regs();
        test_step();
        test_resume();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
